// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse train generator and its benches.
package pulse_gen_pkg;

    localparam int W_LEN_DEF = 8;
    localparam int W_CNT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pgen_down_counter.sv
// Loadable down-counter that saturates at zero; zero flag decoded from the count flop.
module pgen_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load has priority over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable rectangular pulse train generator with busy/done handshake.
// Optional abort input enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_generator
    import pulse_gen_pkg::*;
#(
    parameter int W_LEN = W_LEN_DEF,
    parameter int W_CNT = W_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PULSE_TRAIN_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [W_LEN-1:0] high_len,
    input  logic [W_LEN-1:0] low_len,
    input  logic [W_CNT-1:0] num_pulses,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [W_LEN-1:0] high_len_q, high_len_d;
    logic [W_LEN-1:0] low_len_q, low_len_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             abort_s;
    logic             phase_load_s, phase_en_s, phase_zero_s;
    logic [W_LEN-1:0] phase_load_val_s;
    logic             rem_load_s, rem_en_s, rem_zero_s;
    logic [W_CNT-1:0] rem_load_val_s;

`ifdef PULSE_TRAIN_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // A phase of length L runs while the counter goes from max(L,1)-1 down to 0.
    function automatic logic [W_LEN-1:0] phase_reload(input logic [W_LEN-1:0] len);
        if (len == {W_LEN{1'b0}}) begin
            phase_reload = {W_LEN{1'b0}};
        end else begin
            phase_reload = len - {{(W_LEN-1){1'b0}}, 1'b1};
        end
    endfunction

    pgen_down_counter #(.W(W_LEN)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (phase_load_s),
        .load_val (phase_load_val_s),
        .en       (phase_en_s),
        .zero     (phase_zero_s)
    );

    // Holds pulses still to come after the current HIGH phase.
    pgen_down_counter #(.W(W_CNT)) u_rem_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (rem_load_s),
        .load_val (rem_load_val_s),
        .en       (rem_en_s),
        .zero     (rem_zero_s)
    );

    // Next-state, parameter latching and counter control.
    always_comb begin
        state_d          = state_q;
        high_len_d       = high_len_q;
        low_len_d        = low_len_q;
        phase_load_s     = 1'b0;
        phase_load_val_s = phase_reload(high_len_q);
        phase_en_s       = 1'b0;
        rem_load_s       = 1'b0;
        rem_load_val_s   = {W_CNT{1'b0}};
        rem_en_s         = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    high_len_d       = high_len;
                    low_len_d        = low_len;
                    phase_load_s     = 1'b1;
                    phase_load_val_s = phase_reload(high_len);
                    rem_load_s       = 1'b1;
                    if (num_pulses == {W_CNT{1'b0}}) begin
                        rem_load_val_s = {W_CNT{1'b0}};
                        state_d        = DONE;
                    end else begin
                        rem_load_val_s = num_pulses - {{(W_CNT-1){1'b0}}, 1'b1};
                        state_d        = HIGH;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (abort_s) begin
                    state_d = DONE;
                end else if (phase_zero_s) begin
                    if (rem_zero_s) begin
                        state_d = DONE;
                    end else begin
                        state_d          = LOW;
                        phase_load_s     = 1'b1;
                        phase_load_val_s = phase_reload(low_len_q);
                        rem_en_s         = 1'b1;
                    end
                end else begin
                    phase_en_s = 1'b1;
                end
            end
            LOW: begin
                if (abort_s) begin
                    state_d = DONE;
                end else if (phase_zero_s) begin
                    state_d          = HIGH;
                    phase_load_s     = 1'b1;
                    phase_load_val_s = phase_reload(high_len_q);
                end else begin
                    phase_en_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pulse_d = (state_d == HIGH);
        busy_d  = (state_d == HIGH) || (state_d == LOW);
        done_d  = (state_d == DONE);
    end

    // State, latched lengths and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            high_len_q <= {W_LEN{1'b0}};
            low_len_q  <= {W_LEN{1'b0}};
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator; abort steps need PULSE_TRAIN_ABORT_EN.
module tb_pulse_train_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] num_pulses;
    logic       pulse;
    logic       busy;
    logic       done;
`ifdef PULSE_TRAIN_ABORT_EN
    logic       abort;
`endif

    int total = 0;
    int bad   = 0;
    int rises;
    int hc, bc, guard;
    logic seen_done;

    pulse_train_generator #(.W_LEN(8), .W_CNT(8)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PULSE_TRAIN_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic p, input logic b, input logic d);
        chk({tag, "_pulse"}, {31'd0, pulse}, {31'd0, p});
        chk({tag, "_busy"},  {31'd0, busy},  {31'd0, b});
        chk({tag, "_done"},  {31'd0, done},  {31'd0, d});
    endtask

    // Bit c of ep/eb/ed is the expected value in the (c+1)th cycle after the start edge.
    task automatic run_train(input string tag, input logic [7:0] hl, input logic [7:0] ll,
                             input logic [7:0] np, input int n, input logic hold,
                             input logic poke, input logic [31:0] ep, input logic [31:0] eb,
                             input logic [31:0] ed, output int nrise);
        logic prev;
        prev  = 1'b0;
        nrise = 0;
        high_len   = hl;
        low_len    = ll;
        num_pulses = np;
        start      = 1'b1;
        tick();
        if (!hold) begin
            high_len   = 8'd7;
            low_len    = 8'd7;
            num_pulses = 8'd0;
        end
        for (int c = 0; c < n; c++) begin
            start = hold | (poke && (c == 0));
            chk3($sformatf("%s_c%0d", tag, c + 1), ep[c], eb[c], ed[c]);
            if (pulse && !prev) nrise++;
            prev = pulse;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        high_len   = 8'd0;
        low_len    = 8'd0;
        num_pulses = 8'd0;
`ifdef PULSE_TRAIN_ABORT_EN
        abort      = 1'b0;
`endif
        #12;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk3("post_reset_idle", 1'b0, 1'b0, 1'b0);

        // 1/1/3: line 10101, done in cycle 6.
        run_train("t1", 8'd1, 8'd1, 8'd3, 7, 1'b0, 1'b0, 32'h15, 32'h1F, 32'h20, rises);

        // 1/2/2: line 1001, two pulses, done in cycle 5.
        run_train("t2", 8'd1, 8'd2, 8'd2, 6, 1'b0, 1'b0, 32'h09, 32'h0F, 32'h10, rises);
        chk("t2_rises", rises, 32'd2);

        // Zero lengths act as 1.
        run_train("t3a", 8'd0, 8'd0, 8'd2, 5, 1'b0, 1'b0, 32'h05, 32'h07, 32'h08, rises);
        // Empty train: done right after start, never busy.
        run_train("t3b", 8'd0, 8'd0, 8'd0, 2, 1'b0, 1'b0, 32'h00, 32'h00, 32'h01, rises);

        // Start held: back-to-back 110 110 110 with done in each low cycle.
        run_train("t4", 8'd2, 8'd1, 8'd1, 9, 1'b1, 1'b0, 32'h0DB, 32'h0DB, 32'h124, rises);
        repeat (6) tick();
        chk3("t4_drain", 1'b0, 1'b0, 1'b0);

        // Start while busy (with an empty-train request) must be ignored.
        run_train("poke", 8'd3, 8'd1, 8'd1, 5, 1'b0, 1'b1, 32'h07, 32'h07, 32'h08, rises);

        // Asynchronous reset mid-HIGH.
        high_len   = 8'd4;
        low_len    = 8'd1;
        num_pulses = 8'd5;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk3("t5_pre", 1'b1, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk3("t5_async", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3($sformatf("t5_after%0d", i), 1'b0, 1'b0, 1'b0);
        end
        run_train("t5_fresh", 8'd1, 8'd1, 8'd3, 7, 1'b0, 1'b0, 32'h15, 32'h1F, 32'h20, rises);

        // Full-length phases: 255 high, 255 low, 2 pulses.
        high_len   = 8'hFF;
        low_len    = 8'hFF;
        num_pulses = 8'd2;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        hc        = 0;
        bc        = 0;
        seen_done = 1'b0;
        guard     = 0;
        while (!seen_done && guard < 2000) begin
            if (pulse) hc++;
            if (busy) bc++;
            if (done) seen_done = 1'b1;
            guard++;
            tick();
        end
        chk("max_done_seen", {31'd0, seen_done}, 32'd1);
        chk("max_high_cycles", hc, 32'd510);
        chk("max_busy_cycles", bc, 32'd765);
        tick();

`ifdef PULSE_TRAIN_ABORT_EN
        // Abort in the 2nd HIGH cycle: line drops next cycle, one done.
        high_len   = 8'd4;
        low_len    = 8'd1;
        num_pulses = 8'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk3("t6_high2", 1'b1, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk3("t6_done", 1'b0, 1'b0, 1'b1);
        tick();
        chk3("t6_idle", 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
